// File: rtl/bit_collector8.sv
// bit_collector8: serial-to-parallel collector.
// Each accepted bit is steered into position idx (or N-1-idx) of an assembly
// register. The completed word is presented on a registered valid/ready port.
// The completing bit is merged on the fly, so a word is available the cycle
// after its last bit. Back-to-back words stream with no bubble.
module bit_collector8 #(
  parameter int N         = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_bit,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic                 i_clear,
  output logic [N-1:0]         o_data,
  output logic                 o_valid,
  input  logic                 o_ready,
  output logic [$clog2(N)-1:0] o_count
);

  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0] idx;
  logic [N-1:0]  sr;
  logic [N-1:0]  sr_next;
  logic [IW-1:0] pos;
  logic          last;
  logic          accept;
  logic          done;

  assign last    = (idx == LAST_IDX);
  // Stall only when the completing bit would overwrite a word still held.
  assign i_ready = !i_clear && (!last || !o_valid || o_ready);
  assign accept  = i_valid && i_ready;
  assign done    = accept && last;
  assign o_count = idx;

  // Bit position for the current index, then the assembly word with it merged in.
  always_comb begin
    pos          = LSB_FIRST ? idx : (LAST_IDX - idx);
    sr_next      = sr;
    sr_next[pos] = i_bit;
  end

  // Index/assembly register and the output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      sr      <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      if (i_clear) begin
        idx <= '0;
      end else if (accept) begin
        sr  <= sr_next;
        idx <= last ? '0 : idx + 1'b1;
      end
      if (done) begin
        o_data  <= sr_next;
        o_valid <= 1'b1;
      end else if (o_valid && o_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bit_collector8.sv
// Bench for bit_collector8: two instances (LSB-first and MSB-first) share one
// stimulus stream. A queue-based model of the partial word predicts both
// outputs. Directed scenarios pin literal words, then a random run follows.
module tb_bit_collector8;
  localparam int N = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_bit = 1'b0, i_valid = 1'b0, i_clear = 1'b0, o_ready = 1'b0;
  logic rdy_l, ov_l, rdy_m, ov_m;
  logic [N-1:0] od_l, od_m;
  logic [2:0] cnt_l, cnt_m;

  always #5 clk = ~clk;

  bit_collector8 #(.N(N), .LSB_FIRST(1'b1)) dut_l (
    .clk(clk), .rst(rst), .i_bit(i_bit), .i_valid(i_valid), .i_ready(rdy_l),
    .i_clear(i_clear), .o_data(od_l), .o_valid(ov_l), .o_ready(o_ready),
    .o_count(cnt_l));

  bit_collector8 #(.N(N), .LSB_FIRST(1'b0)) dut_m (
    .clk(clk), .rst(rst), .i_bit(i_bit), .i_valid(i_valid), .i_ready(rdy_m),
    .i_clear(i_clear), .o_data(od_m), .o_valid(ov_m), .o_ready(o_ready),
    .o_count(cnt_m));

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: bits of the partial word in arrival order, plus the held word.
  bit           q[$];
  logic         m_ov = 1'b0;
  logic [N-1:0] m_wl = '0;
  logic [N-1:0] m_wm = '0;
  bit           on = 1'b0;

  function automatic logic m_rdy();
    return !i_clear && (q.size() != N - 1 || !m_ov || o_ready);
  endfunction

  always @(posedge clk) begin
    on = 1'b1;
    if (rst) begin
      q.delete();
      m_ov = 1'b0;
      m_wl = '0;
      m_wm = '0;
    end else begin : upd
      logic acc, done;
      acc  = i_valid && m_rdy();
      done = acc && (q.size() == N - 1);
      if (i_clear) q.delete();
      else if (acc) q.push_back(i_bit);
      if (done) begin
        for (int k = 0; k < N; k++) begin
          m_wl[k]       = q[k];
          m_wm[N-1-k]   = q[k];
        end
        q.delete();
        m_ov = 1'b1;
      end else if (m_ov && o_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (on) begin
      chk("i_ready_lsb", rdy_l, m_rdy());
      chk("i_ready_msb", rdy_m, m_rdy());
      chk("o_valid_lsb", ov_l, m_ov);
      chk("o_valid_msb", ov_m, m_ov);
      chk("o_count_lsb", cnt_l, q.size());
      chk("o_count_msb", cnt_m, q.size());
      if (m_ov) begin
        chk("o_data_lsb", od_l, m_wl);
        chk("o_data_msb", od_m, m_wm);
      end
    end
  end

  // One beat: drive, sample combinational ready, cross the edge.
  task automatic cyc(input logic b, v, c, r, output logic rl);
    i_bit = b; i_valid = v; i_clear = c; o_ready = r;
    #1 rl = rdy_l;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] w, input logic r, output logic all_rdy);
    logic rl;
    all_rdy = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cyc(w[k], 1'b1, 1'b0, r, rl);
      all_rdy = all_rdy & rl;
    end
  endtask

  initial begin
    logic rl, ar;
    logic [7:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ov_l, 1'b0);
    chk("rst_count", cnt_l, 3'd0);
    chk("rst_data", od_l, 8'h00);
    rst = 1'b0;

    // Bits 1,0,1,1,0,0,1,0 in arrival order.
    send_byte(8'h4D, 1'b1, ar);
    chk("t1_valid", ov_l, 1'b1);
    chk("t1_data_lsb", od_l, 8'h4D);
    chk("t1_data_msb", od_m, 8'hB2);
    chk("t1_model", m_wl, 8'h4D);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rl);
    chk("t1_valid_drop", ov_l, 1'b0);

    // Back-to-back words, consumer always ready.
    send_byte(8'hA5, 1'b1, ar);
    chk("b2b_w1", od_l, 8'hA5);
    chk("b2b_rdy1", ar, 1'b1);
    send_byte(8'h3C, 1'b1, ar);
    chk("b2b_w2", od_l, 8'h3C);
    chk("b2b_rdy2", ar, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rl);

    // Backpressure on the completing bit.
    send_byte(8'hFF, 1'b0, ar);
    w = 8'h12;
    for (int k = 0; k < 7; k++) cyc(w[k], 1'b1, 1'b0, 1'b0, rl);
    cyc(w[7], 1'b1, 1'b0, 1'b0, rl);
    chk("bp_ready_low", rl, 1'b0);
    chk("bp_hold_data", od_l, 8'hFF);
    chk("bp_hold_count", cnt_l, 3'd7);
    cyc(w[7], 1'b1, 1'b0, 1'b1, rl);
    chk("bp_ready_high", rl, 1'b1);
    chk("bp_new_word", od_l, 8'h12);
    chk("bp_new_valid", ov_l, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rl);

    // Clear mid-word with a pending output word.
    send_byte(8'h55, 1'b0, ar);
    repeat (3) cyc(1'b1, 1'b1, 1'b0, 1'b0, rl);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, rl);
    chk("clr_ready", rl, 1'b0);
    chk("clr_count", cnt_l, 3'd0);
    chk("clr_pending", ov_l, 1'b1);
    chk("clr_data", od_l, 8'h55);
    send_byte(8'hC3, 1'b1, ar);
    chk("clr_next_word", od_l, 8'hC3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rl);

    // Reset mid-word with a pending output word.
    send_byte(8'h0F, 1'b0, ar);
    repeat (5) cyc(1'b1, 1'b1, 1'b0, 1'b0, rl);
    chk("mrst_pre_count", cnt_l, 3'd5);
    rst = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, rl);
    rst = 1'b0;
    chk("mrst_valid", ov_l, 1'b0);
    chk("mrst_data", od_l, 8'h00);
    chk("mrst_count", cnt_l, 3'd0);
    send_byte(8'h96, 1'b1, ar);
    chk("mrst_word_lsb", od_l, 8'h96);
    chk("mrst_word_msb", od_m, 8'h69);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, rl);

    // Random traffic.
    for (int c = 0; c < 2048; c++)
      cyc(1'($urandom % 2), 1'($urandom % 4 != 0), 1'($urandom % 32 == 0),
          1'($urandom % 5 < 3), rl);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
